// File: rtl/bresenham_line_stream_if.sv
// rtl/bresenham_line_stream_if.sv - command and pixel handshake bundle for the line rasteriser
interface bresenham_line_stream_if #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 17
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic signed [COORD_W-1:0] cmd_x0;
  logic signed [COORD_W-1:0] cmd_y0;
  logic signed [COORD_W-1:0] cmd_x1;
  logic signed [COORD_W-1:0] cmd_y1;
  logic                      pix_valid;
  logic                      pix_ready;
  logic signed [COORD_W-1:0] pix_x;
  logic signed [COORD_W-1:0] pix_y;
  logic                      pix_last;
  logic [CNT_W-1:0]          pix_idx;

  // upstream command source / downstream pixel sink side
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, pix_ready,
    input  cmd_ready, pix_valid, pix_x, pix_y, pix_last, pix_idx
  );

  // rasteriser side
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, pix_ready,
    output cmd_ready, pix_valid, pix_x, pix_y, pix_last, pix_idx
  );
endinterface

// File: rtl/bresenham_line_stream.sv
// rtl/bresenham_line_stream.sv - sequential Bresenham rasteriser streaming one pixel per clock
module bresenham_line_stream #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  output logic                  busy,
  bresenham_line_stream_if.slave bus
);
  localparam int DW = COORD_W + 1;  // endpoint difference width, holds full-range spans
  localparam int EW = COORD_W + 3;  // error term width, holds 2*err without overflow

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic signed [COORD_W-1:0] x, y, x_end, y_end;
  logic [DW-1:0]             dx, dy;
  logic                      sx_neg, sy_neg;
  logic signed [EW-1:0]      err;
  logic [CNT_W-1:0]          idx;

  logic signed [DW-1:0]      diff_x, diff_y;
  logic signed [EW-1:0]      dx_s, dy_s, e2, err_nxt;
  logic                      step_x, step_y;
  logic                      accept, handshake, step;
  logic                      last;

  // command setup: sign-extended differences and their magnitudes
  assign diff_x = DW'(bus.cmd_x1) - DW'(bus.cmd_x0);
  assign diff_y = DW'(bus.cmd_y1) - DW'(bus.cmd_y0);

  // error-term step; both comparisons use the same pre-update e2
  assign dx_s    = $signed({2'b00, dx});
  assign dy_s    = $signed({2'b00, dy});
  assign e2      = err <<< 1;
  assign step_x  = (e2 > -dy_s);
  assign step_y  = (e2 < dx_s);
  assign err_nxt = err - (step_x ? dy_s : '0) + (step_y ? dx_s : '0);

  assign last      = (state == RUN) && (x == x_end) && (y == y_end);
  assign accept    = (state == IDLE) && bus.cmd_valid;
  assign handshake = (state == RUN) && bus.pix_ready;
  assign step      = handshake && !last && !abort;

  assign bus.pix_x    = x;
  assign bus.pix_y    = y;
  assign bus.pix_idx  = idx;
  assign bus.pix_last = last;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and handshake outputs; abort beats the final handshake
  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.pix_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = RUN;
      end
      RUN: begin
        bus.pix_valid = 1'b1;
        busy          = 1'b1;
        if (abort)                         state_nxt = IDLE;
        else if (bus.pix_ready && last)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // line datapath: load on accept, advance one pixel per non-final handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      x_end  <= '0;
      y_end  <= '0;
      dx     <= '0;
      dy     <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      err    <= '0;
      idx    <= '0;
    end else if (accept) begin
      x      <= bus.cmd_x0;
      y      <= bus.cmd_y0;
      x_end  <= bus.cmd_x1;
      y_end  <= bus.cmd_y1;
      dx     <= diff_x[DW-1] ? DW'(-diff_x) : DW'(diff_x);
      dy     <= diff_y[DW-1] ? DW'(-diff_y) : DW'(diff_y);
      sx_neg <= !(bus.cmd_x0 < bus.cmd_x1);
      sy_neg <= !(bus.cmd_y0 < bus.cmd_y1);
      err    <= EW'(dx_from_cmd(diff_x)) - EW'(dx_from_cmd(diff_y));
      idx    <= '0;
    end else if (step) begin
      if (step_x) x <= sx_neg ? x - COORD_W'(1) : x + COORD_W'(1);
      if (step_y) y <= sy_neg ? y - COORD_W'(1) : y + COORD_W'(1);
      err <= err_nxt;
      idx <= idx + CNT_W'(1);
    end
  end

  // magnitude of a signed endpoint difference, zero-extended for the error term
  function automatic logic [DW-1:0] dx_from_cmd(input logic signed [DW-1:0] d);
    return d[DW-1] ? DW'(-d) : DW'(d);
  endfunction

endmodule

// File: tb/tb_bresenham_line_stream.sv
// tb/tb_bresenham_line_stream.sv - directed self-checking bench for the line rasteriser
module tb_bresenham_line_stream;
  logic clk = 1'b0;
  logic rst_n;
  logic abort;
  logic busy;

  bresenham_line_stream_if #(.COORD_W(16), .CNT_W(17)) bus ();

  bresenham_line_stream #(.COORD_W(16), .CNT_W(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (abort),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q_x[$], q_y[$], q_idx[$];
  bit q_last[$];
  int timed_out, stall_bad, crdy_bad;

  // issue one command in the current cycle; returns one cycle later (post-edge)
  task automatic send_cmd(input int x0, input int y0, input int x1, input int y1);
    bus.cmd_x0 = x0[15:0];
    bus.cmd_y0 = y0[15:0];
    bus.cmd_x1 = x1[15:0];
    bus.cmd_y1 = y1[15:0];
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // record accepted pixels until the last one handshakes (mode 1: ready pattern 1,0,0)
  task automatic collect(input int mode, input int budget);
    bit done = 0;
    bit prev_stall = 0;
    int px = 0, py = 0, pi = 0;
    q_x.delete(); q_y.delete(); q_idx.delete(); q_last.delete();
    timed_out = 1; stall_bad = 0; crdy_bad = 0;
    for (int c = 0; c < budget; c++) begin
      bus.pix_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      if (prev_stall && bus.pix_valid &&
          (int'(bus.pix_x) != px || int'(bus.pix_y) != py || int'(bus.pix_idx) != pi))
        stall_bad++;
      if (bus.pix_valid && bus.cmd_ready) crdy_bad++;
      if (bus.pix_valid && bus.pix_ready) begin
        q_x.push_back(int'(bus.pix_x));
        q_y.push_back(int'(bus.pix_y));
        q_idx.push_back(int'(bus.pix_idx));
        q_last.push_back(bus.pix_last);
        done = bus.pix_last;
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      px = int'(bus.pix_x); py = int'(bus.pix_y); pi = int'(bus.pix_idx);
      @(posedge clk); #1;
      if (done) begin
        timed_out = 0;
        break;
      end
    end
    if (timed_out != 0) begin
      checks++; errors++;
      $display("FAIL collect_timeout: got no last pixel within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL rst_pix_valid: got %b expected 0", bus.pix_valid); end
    checks++; if (busy !== 1'b0 || bus.pix_last !== 1'b0) begin errors++; $display("FAIL rst_busy_last: got %b%b expected 00", busy, bus.pix_last); end
    checks++; if (bus.pix_idx !== 17'd0 || bus.pix_x !== 16'sd0) begin errors++; $display("FAIL rst_idx_x: got %0d,%0d expected 0,0", bus.pix_idx, bus.pix_x); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    // mid-line reset at pixel 3 of 10
    send_cmd(0, 0, 9, 0);
    bus.pix_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.pix_x !== 16'sd3) begin errors++; $display("FAIL midline_pix3: got %0d expected 3", bus.pix_x); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pix_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got valid=%b ready=%b expected valid=0 ready=1", bus.pix_valid, bus.cmd_ready); end
    checks++; if (bus.pix_x !== 16'sd0 || bus.pix_idx !== 17'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset_vals: got x=%0d idx=%0d busy=%b expected 0 0 0", bus.pix_x, bus.pix_idx, busy); end
    @(posedge clk); #1; rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (5) begin @(posedge clk); #1; if (bus.pix_valid) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL residual_pixels: got %0d expected 0", seen); end
    end
  endtask

  task automatic test_shallow();
    int ex[6] = '{0, 1, 2, 3, 4, 5};
    int ey[6] = '{0, 0, 1, 1, 2, 2};
    bus.pix_ready = 1'b0;
    send_cmd(0, 0, 5, 2);
    checks++; if (bus.pix_valid !== 1'b1 || bus.pix_idx !== 17'd0) begin errors++; $display("FAIL shallow_latency: got valid=%b idx=%0d expected 1 0", bus.pix_valid, bus.pix_idx); end
    collect(0, 50);
    checks++; if (q_x.size() !== 6) begin errors++; $display("FAIL shallow_count: got %0d expected 6", q_x.size()); end
    for (int i = 0; i < 6 && i < q_x.size(); i++) begin
      checks++;
      if (q_x[i] !== ex[i] || q_y[i] !== ey[i] || q_idx[i] !== i || q_last[i] !== (i == 5))
        begin errors++; $display("FAIL shallow_pix%0d: got (%0d,%0d) idx=%0d last=%b expected (%0d,%0d) idx=%0d last=%b", i, q_x[i], q_y[i], q_idx[i], q_last[i], ex[i], ey[i], i, (i == 5)); end
    end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.pix_valid !== 1'b0) begin errors++; $display("FAIL shallow_idle: got ready=%b valid=%b expected 1 0", bus.cmd_ready, bus.pix_valid); end
  endtask

  task automatic test_steep();
    int ex[7] = '{3, 3, 2, 2, 2, 1, 1};
    int ey[7] = '{4, 3, 2, 1, 0, -1, -2};
    send_cmd(3, 4, 1, -2);
    collect(0, 50);
    checks++; if (q_x.size() !== 7) begin errors++; $display("FAIL steep_count: got %0d expected 7", q_x.size()); end
    for (int i = 0; i < 7 && i < q_x.size(); i++) begin
      checks++;
      if (q_x[i] !== ex[i] || q_y[i] !== ey[i] || q_idx[i] !== i)
        begin errors++; $display("FAIL steep_pix%0d: got (%0d,%0d) idx=%0d expected (%0d,%0d) idx=%0d", i, q_x[i], q_y[i], q_idx[i], ex[i], ey[i], i); end
    end
  endtask

  task automatic test_backpressure();
    send_cmd(0, 0, 4, 4);
    collect(1, 100);
    checks++; if (q_x.size() !== 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", q_x.size()); end
    for (int i = 0; i < 5 && i < q_x.size(); i++) begin
      checks++;
      if (q_x[i] !== i || q_y[i] !== i || q_idx[i] !== i)
        begin errors++; $display("FAIL bp_pix%0d: got (%0d,%0d) idx=%0d expected (%0d,%0d) idx=%0d", i, q_x[i], q_y[i], q_idx[i], i, i, i); end
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_bad); end
    checks++; if (crdy_bad !== 0) begin errors++; $display("FAIL bp_cmd_ready_low: got %0d cycles high expected 0", crdy_bad); end
  endtask

  task automatic test_degenerate();
    send_cmd(7, 7, 7, 7);
    collect(0, 10);
    checks++; if (q_x.size() !== 1) begin errors++; $display("FAIL degen_count: got %0d expected 1", q_x.size()); end
    if (q_x.size() > 0) begin
      checks++;
      if (q_x[0] !== 7 || q_y[0] !== 7 || q_idx[0] !== 0 || q_last[0] !== 1'b1)
        begin errors++; $display("FAIL degen_pix: got (%0d,%0d) idx=%0d last=%b expected (7,7) idx=0 last=1", q_x[0], q_y[0], q_idx[0], q_last[0]); end
    end
  endtask

  task automatic test_extreme();
    int bad = 0;
    send_cmd(-32768, 0, 32767, 0);
    collect(0, 70000);
    checks++; if (q_x.size() !== 65536) begin errors++; $display("FAIL extreme_count: got %0d expected 65536", q_x.size()); end
    for (int i = 0; i < q_x.size(); i++)
      if (q_x[i] != -32768 + i || q_y[i] != 0 || q_idx[i] != i || q_last[i] != (i == 65535)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL extreme_sequence: got %0d bad pixels expected 0", bad); end
    if (q_x.size() > 0) begin
      checks++;
      if (q_idx[q_idx.size()-1] !== 65535 || q_x[q_x.size()-1] !== 32767)
        begin errors++; $display("FAIL extreme_last: got idx=%0d x=%0d expected idx=65535 x=32767", q_idx[q_idx.size()-1], q_x[q_x.size()-1]); end
    end
  endtask

  task automatic test_abort();
    send_cmd(0, 0, 10, 0);
    bus.pix_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (bus.pix_x !== 16'sd4 || bus.pix_valid !== 1'b1) begin errors++; $display("FAIL abort_pre: got x=%0d valid=%b expected x=4 valid=1", bus.pix_x, bus.pix_valid); end
    abort = 1'b1;
    bus.pix_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.pix_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got valid=%b ready=%b busy=%b expected 0 1 0", bus.pix_valid, bus.cmd_ready, busy); end
    // abort held high in IDLE must not block the next command
    send_cmd(2, 2, 3, 3);
    abort = 1'b0;
    checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL abort_idle_accept: got valid=%b expected 1", bus.pix_valid); end
    collect(0, 20);
    checks++; if (q_x.size() !== 2) begin errors++; $display("FAIL abort_next_count: got %0d expected 2", q_x.size()); end
    for (int i = 0; i < 2 && i < q_x.size(); i++) begin
      checks++;
      if (q_x[i] !== 2 + i || q_y[i] !== 2 + i)
        begin errors++; $display("FAIL abort_next_pix%0d: got (%0d,%0d) expected (%0d,%0d)", i, q_x[i], q_y[i], 2 + i, 2 + i); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;
    bus.pix_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_shallow();
    test_steep();
    test_backpressure();
    test_degenerate();
    test_extreme();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bresenham_line_stream.md
Name: bresenham_line_stream

Overview:
Sequential, parametrised Bresenham line rasteriser. It accepts one line command (two signed endpoints) through a valid/ready handshake. It then streams every pixel of the line, endpoints inclusive, at up to one pixel per clock, with output backpressure and abort. It sits between the primitive command queue and the framebuffer write path, and replaces the combinational, single-result line block.

Parameters:
COORD_W, 16, width of signed x/y coordinates (>=4)
CNT_W, 17, width of pixel index counter; must be >= COORD_W+1

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  line command present
cmd_ready  out  1  block can accept a command
cmd_x0  in  COORD_W  signed start x
cmd_y0  in  COORD_W  signed start y
cmd_x1  in  COORD_W  signed end x
cmd_y1  in  COORD_W  signed end y
abort  in  1  synchronous cancel of current line
pix_valid  out  1  pix_x/pix_y hold a valid pixel
pix_ready  in  1  downstream accepts pixel
pix_x  out  COORD_W  signed pixel x
pix_y  out  COORD_W  signed pixel y
pix_last  out  1  current pixel is the endpoint (x1,y1)
pix_idx  out  CNT_W  zero-based index of current pixel in line
busy  out  1  line in progress (state RUN)

Behaviour:
- Reset (rst_n low, async): state IDLE; cmd_ready=1; pix_valid=0; pix_last=0; busy=0; pix_x, pix_y, pix_idx=0; internal err/dx/dy/sx/sy cleared.
- States: IDLE, RUN.
- IDLE: cmd_ready=1, pix_valid=0. On cmd_valid&cmd_ready:
  - Register x1,y1.
  - dx=|x1-x0|, dy=|y1-y0|, each unsigned COORD_W+1 bits, so full-range differences do not overflow.
  - sx=+1 if x0<x1, else -1; sy=+1 if y0<y1, else -1. Equal endpoints give -1; this is harmless because the step never fires.
  - err=dx-dy, signed COORD_W+3 bits.
  - pix_x=x0, pix_y=y0, pix_idx=0.
  - Go to RUN.
- Latency: first pixel has pix_valid=1 in the cycle after command acceptance.
- RUN: cmd_ready=0, busy=1, pix_valid=1.
  - pix_last is combinational: (pix_x==x1 && pix_y==y1).
  - Outputs hold stable while pix_valid&!pix_ready.
- Step on a pix_valid&pix_ready handshake with pix_last=0:
  - e2=2*err, signed COORD_W+3 bits.
  - Both comparisons use the same pre-update e2.
  - If e2 > -dy: x+=sx, err-=dy.
  - If e2 < dx: y+=sy, err+=dx.
  - Both may fire in one cycle; the err update is the sum of both terms.
  - pix_idx increments by 1.
- Handshake with pix_last=1: go to IDLE; cmd_ready=1 and pix_valid=0 the next cycle. No back-to-back overlap: minimum one idle cycle between lines.
- Pixel count per line is exactly max(dx,dy)+1. pix_idx of the last pixel is max(dx,dy).
- Degenerate line (x0==x1, y0==y1): exactly one pixel, with pix_last=1 and pix_idx=0.
- Coordinate arithmetic never wraps within a legal line, since all intermediate points lie between the endpoints.
- abort (RUN): has priority over the step.
  - Next cycle: state IDLE, pix_valid=0, cmd_ready=1.
  - A pixel handshaking in the same cycle counts as consumed.
  - abort in IDLE is ignored, and a simultaneous cmd_valid is still accepted.
- rst_n asserted mid-line: immediate return to reset values. No residual pixels after reset release.

Test Plan:
- Reset: assert rst_n=0 mid-line (pixel 3 of 10) -> pix_valid=0, cmd_ready=1 immediately. After release, no pixel appears until a new command.
- Shallow line (0,0)->(5,2), pix_ready=1 -> 6 pixels: (0,0)(1,0)(2,1)(3,1)(4,2)(5,2). pix_last only on (5,2); pix_idx 0..5; first pixel 1 cycle after acceptance.
- Steep negative line (3,4)->(1,-2) -> 7 pixels. y steps -1 every pixel; x stays in [1,3]; ends at (1,-2) with pix_idx=6.
- Backpressure: (0,0)->(4,4) with pix_ready toggling 1,0,0,1,... -> pixels (0,0)..(4,4) each exactly once. Outputs stable during stall cycles; cmd_ready stays 0 until the last handshake.
- Degenerate and extremes: (7,7)->(7,7) gives a single pixel with pix_last=1. Then (-32768,0)->(32767,0) gives 65536 pixels with final pix_idx=65535 and no overflow.
- Abort: (0,0)->(10,0), abort after 4th handshake -> next cycle pix_valid=0, cmd_ready=1. A new command (2,2)->(3,3) accepted immediately yields (2,2)(3,3).
